// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    // Iterative ops occupy the lower half of the opcode space.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned N = MD_WIDTH
) (
    input  mode_t            mode,
    input  logic [2*N-1:0]   acc,
    input  logic [N-1:0]     operand,
    output logic [2*N-1:0]   acc_next,
    output logic             qbit
);

    logic [N:0]   sum;
    logic [N:0]   rem_wide;
    logic [N-1:0] diff;
    logic         ge;

    // Multiply: conditional add into upper half, shift right.
    // Divide: shift {rem, dividend} left, trial-subtract divisor.
    always_comb begin
        sum      = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, operand} : {(N+1){1'b0}});
        rem_wide = acc[2*N-1:N-1];
        // Only used when rem_wide >= operand, so the true difference fits in N bits.
        diff     = rem_wide[N-1:0] - operand;
        ge       = (rem_wide >= {1'b0, operand});
        acc_next = acc;
        qbit     = 1'b0;
        if (mode == MODE_MUL) begin
            acc_next = {sum, acc[N-1:1]};
        end else begin
            acc_next = {(ge ? diff : rem_wide[N-1:0]), acc[N-2:0], 1'b0};
            qbit     = ge;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned N = MD_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);

    state_t         state;
    mode_t          mode;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [N-1:0]   operand;
    logic [N-1:0]   a_orig;
    logic           res_neg;
    logic           rem_neg;
    logic           dbz_pend;

    logic [2*N-1:0] step_acc;
    logic           step_q;
    logic [N-1:0]   fix_hi;
    logic [N-1:0]   fix_lo;
    logic           op_signed;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;

    // Two's-complement magnitude for signed ops; 0x80..0 maps to itself as unsigned.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic sgn);
        return (sgn && x[N-1]) ? (~x + N'(1)) : x;
    endfunction

    muldiv_step #(.N(N)) u_step (
        .mode     (mode),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc),
        .qbit     (step_q)
    );

    // Operand magnitudes for the accept edge.
    always_comb begin
        op_signed = ~op[0];
        mag_a     = magnitude(a, op_signed);
        mag_b     = magnitude(b, op_signed);
    end

    // Final sign correction and divide-by-zero substitution.
    always_comb begin
        fix_hi = acc[2*N-1:N];
        fix_lo = acc[N-1:0];
        if (mode == MODE_MUL) begin
            if (res_neg) begin
                {fix_hi, fix_lo} = ~acc + (2*N)'(1);
            end
        end else if (dbz_pend) begin
            fix_lo = '1;
            fix_hi = a_orig;
        end else begin
            if (res_neg) begin
                fix_lo = ~acc[N-1:0] + N'(1);
            end
            if (rem_neg) begin
                fix_hi = ~acc[2*N-1:N] + N'(1);
            end
        end
    end

    // Sequencer FSM, working registers and HI/LO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode        <= MODE_MUL;
            cnt         <= '0;
            acc         <= '0;
            operand     <= '0;
            a_orig      <= '0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            dbz_pend    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_iterative(op)) begin
                            cnt         <= '0;
                            a_orig      <= a;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= RUN;
                            res_neg     <= op_signed & (a[N-1] ^ b[N-1]);
                            if (op[1]) begin
                                mode     <= MODE_DIV;
                                acc      <= {{N{1'b0}}, mag_a};
                                operand  <= mag_b;
                                rem_neg  <= op_signed & a[N-1];
                                dbz_pend <= (b == '0);
                            end else begin
                                mode     <= MODE_MUL;
                                acc      <= {{N{1'b0}}, mag_b};
                                operand  <= mag_a;
                                rem_neg  <= 1'b0;
                                dbz_pend <= 1'b0;
                            end
                        end else if (op == OP_MTHI) begin
                            hi          <= a;
                            done        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end else if (op == OP_MTLO) begin
                            lo          <= a;
                            done        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc <= {step_acc[2*N-1:1], (mode == MODE_DIV) ? step_q : step_acc[0]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= dbz_pend;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    localparam int unsigned N    = 32;
    localparam int          LAT  = 33;
    localparam int          MAXW = 40;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int n;

    muldiv_ctrl #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a command at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < MAXW) begin
            @(posedge clock);
            cnt++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [N-1:0] ehi,
                          input logic [N-1:0] elo, input logic edbz);
        int c;
        issue(o, x, y);
        check({tag, " busy"}, busy, 1'b1);
        wait_done(c);
        check({tag, " latency"}, c, LAT);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        check({tag, " dbz"}, div_by_zero, edbz);
        check({tag, " busy_at_done"}, busy, 1'b0);
        @(negedge clock);
        check({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset dbz", div_by_zero, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        // Give hi a nonzero value, then abort a MULTU with reset.
        issue(3'b100, 32'h0000DEAD, 32'h0);
        check("pre mthi", hi, 32'h0000DEAD);
        issue(3'b001, 32'd7, 32'd6);
        repeat (10) @(negedge clock);
        check("midrun busy", busy, 1'b1);
        check("midrun hi hold", hi, 32'h0000DEAD);
        reset = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort done", done, 1'b0);
        repeat (3) @(negedge clock);
        check("abort no done", done, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        run_op("multu 7*6", 3'b001, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0);
        run_op("mult -3*5", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("multu max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("div -7/2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu 100/7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_op("divu 9/0", 3'b011, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);

        // MTLO clears the divide-by-zero flag and leaves hi alone.
        issue(3'b101, 32'h00000055, 32'h0);
        check("mtlo done", done, 1'b1);
        check("mtlo dbz clr", div_by_zero, 1'b0);
        check("mtlo lo", lo, 32'h00000055);
        check("mtlo hi hold", hi, 32'd9);

        // Reserved opcode is ignored.
        issue(3'b110, 32'hAAAAAAAA, 32'h0);
        check("rsvd done", done, 1'b0);
        check("rsvd busy", busy, 1'b0);
        check("rsvd lo", lo, 32'h00000055);

        // Back-to-back MTHI then MTLO.
        start = 1'b1; op = 3'b100; a = 32'h12345678; b = '0;
        @(posedge clock);
        @(negedge clock);
        check("mthi done", done, 1'b1);
        check("mthi busy", busy, 1'b0);
        check("mthi hi", hi, 32'h12345678);
        op = 3'b101; a = 32'h9ABCDEF0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("mtlo2 done", done, 1'b1);
        check("mtlo2 busy", busy, 1'b0);
        check("mtlo2 lo", lo, 32'h9ABCDEF0);
        check("mtlo2 hi hold", hi, 32'h12345678);
        @(negedge clock);
        check("mt done drop", done, 1'b0);

        // start held high throughout a MULT: only the first executes, done-cycle start is accepted.
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(posedge clock);
        @(negedge clock);
        op = 3'b001; a = 32'd5; b = 32'd5;
        wait_done(n);
        check("storm latency", n, LAT);
        check("storm hi", hi, 32'h0);
        check("storm lo", lo, 32'd12);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("storm reaccept busy", busy, 1'b1);
        check("storm reaccept done", done, 1'b0);
        wait_done(n);
        check("second latency", n, LAT);
        check("second lo", lo, 32'd25);
        check("second hi", hi, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
